// File: rtl/sng_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : sng_multi_if
//  Description : Handshake and data bundle for the multi-channel stochastic
//                number generator (operands in, serial and parallel streams
//                out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sng_multi_if #(
  parameter int N_CH = 2,
  parameter int BSL  = 255,
  parameter int W    = 8
);
  localparam int IW = (BSL > 1) ? $clog2(BSL) : 1;

  logic                  start;
  logic                  corr;
  logic [N_CH*W-1:0]     a;
  logic                  busy;
  logic                  done;
  logic                  bit_valid;
  logic [IW-1:0]         bit_idx;
  logic [N_CH-1:0]       bit_out;
  logic [N_CH*BSL-1:0]   a_sbs;

  // Requester side: issues start and operands, observes the streams
  modport master (
    output start, corr, a,
    input  busy, done, bit_valid, bit_idx, bit_out, a_sbs
  );

  // Generator side
  modport slave (
    input  start, corr, a,
    output busy, done, bit_valid, bit_idx, bit_out, a_sbs
  );
endinterface
`default_nettype wire

// File: rtl/sng_multi.sv
`default_nettype none
// ============================================================================
//  Module      : sng_multi
//  Description : N_CH-channel stochastic number generator. Each latched
//                operand is compared against a shared maximal-length LFSR
//                (optionally bit-rotated per channel) to produce a BSL-bit
//                stream, delivered serially and as a parallel register.
//  Revision    : 1.0 - initial release
// ============================================================================
module sng_multi #(
  parameter int             N_CH = 2,
  parameter int             BSL  = 255,
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = 8'hB8,
  parameter logic [W-1:0]   SEED = 8'hF4,
  parameter int             ROT  = 3
) (
  input  wire logic  clk,
  input  wire logic  rst,
  sng_multi_if.slave bus
);
  localparam int            IW       = (BSL > 1) ? $clog2(BSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BSL - 1);

  // An all-zero seed locks the LFSR; a one-bit stream is meaningless
  if (SEED == '0) begin : g_seed_check
    $error("sng_multi: SEED must be nonzero");
  end
  if (BSL < 2) begin : g_bsl_check
    $error("sng_multi: BSL must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W-1:0]          lfsr_q, lfsr_d;
  logic [N_CH*W-1:0]     a_q, a_d;
  logic                  corr_q, corr_d;
  logic [N_CH*BSL-1:0]   sbs_q, sbs_d;

  logic [N_CH-1:0]       stream_bit;
  logic [BSL-1:0]        idx_onehot;

  // One-hot write strobe for the current bit position within a channel
  assign idx_onehot = BSL'(1) << idx_q;

  // Per-channel random value and comparator; rotation is fixed per channel
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int SH = (c * ROT) % W;
    logic [W-1:0] rot;
    logic [W-1:0] rnd;

    if (SH == 0) begin : g_norot
      assign rot = lfsr_q;
    end else begin : g_rot
      assign rot = {lfsr_q[W-1-SH:0], lfsr_q[W-1:W-SH]};
    end

    assign rnd           = corr_q ? lfsr_q : rot;
    assign stream_bit[c] = (a_q[c*W +: W] >= rnd);
  end

  // Next-state logic: start accepted only outside RUN, RUN lasts BSL cycles
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    corr_d  = corr_q;
    sbs_d   = sbs_q;

    case (state_q)
      ST_RUN: begin
        for (int c = 0; c < N_CH; c++) begin
          sbs_d[c*BSL +: BSL] = (sbs_q[c*BSL +: BSL] & ~idx_onehot)
                              | ({BSL{stream_bit[c]}} & idx_onehot);
        end
        lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE behave identically on start; DONE holds done high
        if (bus.start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
          lfsr_d  = SEED;
          a_d     = bus.a;
          corr_d  = bus.corr;
        end
      end
    endcase
  end

  // State register with synchronous reset taking priority over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      lfsr_q  <= SEED;
      a_q     <= '0;
      corr_q  <= 1'b0;
      sbs_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      corr_q  <= corr_d;
      sbs_q   <= sbs_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bit_valid = valid_q;
  assign bus.bit_idx   = idx_q;
  assign bus.bit_out   = stream_bit;
  assign bus.a_sbs     = sbs_q;

endmodule
`default_nettype wire

// File: tb/tb_sng_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sng_multi
//  Description : Self-checking bench for sng_multi with default parameters.
//                Expected streams come from an arithmetic LFSR/compare model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sng_multi;
  localparam int         N_CH = 2;
  localparam int         BSL  = 255;
  localparam int         W    = 8;
  localparam int         ROT  = 3;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'hF4;
  localparam int         SW   = N_CH * BSL;
  localparam int         MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sng_multi_if #(.N_CH(N_CH), .BSL(BSL), .W(W)) bus ();

  sng_multi #(
    .N_CH(N_CH), .BSL(BSL), .W(W), .TAPS(TAPS), .SEED(SEED), .ROT(ROT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a0;
    int a1;
    bit corr;
    int pop0;
    int pop1;
    bit same;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Streams from the definition: walk the LFSR sequence, rotate per channel, compare
  function automatic logic [SW-1:0] model(input int a0, input int a1, input bit cr);
    logic [SW-1:0] s = '0;
    int l = int'(SEED);
    int av[2];
    av[0] = a0;
    av[1] = a1;
    for (int k = 0; k < BSL; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        int r  = cr ? 0 : (c * ROT) % W;
        int rv = ((l << r) | (l >> (W - r))) & MASK;
        s[c*BSL + k] = (av[c] >= rv);
      end
      l = ((l << 1) & MASK) | ($countones(l & int'(TAPS)) & 1);
    end
    return s;
  endfunction

  // Called at a negedge: presents start for one rising edge
  task automatic launch(input int a0, input int a1, input bit cr);
    bus.a     = {a1[7:0], a0[7:0]};
    bus.corr  = cr;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Follows one run to done; optionally pulses an (ignored) start mid-run
  task automatic run_watch(input int a0, input int a1, input bit cr, input int inj_at, input string nm);
    logic [SW-1:0] exp = model(a0, a1, cr);
    int  cnt = 0;
    int  serr = 0;
    bit  got_done = 1'b0;
    for (int n = 0; n < BSL + 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (cnt < BSL) begin
        if (!bus.busy || !bus.bit_valid || int'(bus.bit_idx) != cnt ||
            bus.bit_out !== {exp[BSL + cnt], exp[cnt]})
          serr++;
      end else begin
        serr++;
      end
      if (cnt == inj_at) begin
        bus.start = 1'b1;
        bus.a     = 16'($urandom);
        bus.corr  = ~cr;
      end else begin
        bus.start = 1'b0;
      end
      cnt++;
    end
    bus.start = 1'b0;
    chk({nm, "_done_seen"}, SW'(got_done), SW'(1));
    chk({nm, "_latency"}, SW'(cnt), SW'(BSL));
    chk({nm, "_busy_at_done"}, SW'(bus.busy), SW'(0));
    chk({nm, "_serial"}, SW'(serr), SW'(0));
    chk({nm, "_streams"}, bus.a_sbs, exp);
  endtask

  initial begin
    logic [SW-1:0] saved;

    tbl[0] = '{a0: 0,   a1: 255, corr: 1'b1, pop0: 0,   pop1: 255, same: 1'b0};
    tbl[1] = '{a0: 128, a1: 128, corr: 1'b1, pop0: 128, pop1: 128, same: 1'b1};
    tbl[2] = '{a0: 128, a1: 128, corr: 1'b0, pop0: 128, pop1: 128, same: 1'b0};
    tbl[3] = '{a0: 244, a1: 243, corr: 1'b1, pop0: 244, pop1: 243, same: 1'b0};
    tbl[4] = '{a0: 1,   a1: 254, corr: 1'b0, pop0: 1,   pop1: 254, same: 1'b0};

    bus.start = 1'b0;
    bus.corr  = 1'b0;
    bus.a     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", SW'(bus.busy), SW'(0));
    chk("rst_done", SW'(bus.done), SW'(0));
    chk("rst_valid", SW'(bus.bit_valid), SW'(0));
    chk("rst_idx", SW'(bus.bit_idx), SW'(0));
    chk("rst_bit_out", SW'(bus.bit_out), SW'(0));
    chk("rst_sbs", bus.a_sbs, '0);
    rst = 1'b0;
    @(negedge clk);

    // First bit and LFSR step: SEED F4 then E9
    launch(244, 243, 1'b1);
    @(negedge clk);
    chk("first_busy", SW'(bus.busy), SW'(1));
    chk("first_idx0", SW'(bus.bit_idx), SW'(0));
    chk("first_bit0", SW'(bus.bit_out), SW'(2'b01));
    @(negedge clk);
    chk("first_idx1", SW'(bus.bit_idx), SW'(1));
    chk("first_bit1", SW'(bus.bit_out), SW'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Table: exact popcounts, channel equality, back-to-back restarts from DONE
    for (int i = 0; i < 5; i++) begin
      launch(tbl[i].a0, tbl[i].a1, tbl[i].corr);
      if (i > 0) begin
        chk($sformatf("tbl%0d_done_clear", i), SW'(bus.done), SW'(0));
        chk($sformatf("tbl%0d_busy_set", i), SW'(bus.busy), SW'(1));
      end
      run_watch(tbl[i].a0, tbl[i].a1, tbl[i].corr, -1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_pop0", i), SW'($countones(bus.a_sbs[BSL-1:0])), SW'(tbl[i].pop0));
      chk($sformatf("tbl%0d_pop1", i), SW'($countones(bus.a_sbs[SW-1:BSL])), SW'(tbl[i].pop1));
      chk($sformatf("tbl%0d_same", i), SW'(bus.a_sbs[BSL-1:0] == bus.a_sbs[SW-1:BSL]), SW'(tbl[i].same));
    end

    // Start during RUN is ignored; run ends on schedule with original operands
    launch(77, 200, 1'b0);
    run_watch(77, 200, 1'b0, 50, "ign");
    saved = bus.a_sbs;

    // Restart from DONE reloads the seed and reproduces the streams
    launch(77, 200, 1'b0);
    chk("rerun_done_clear", SW'(bus.done), SW'(0));
    run_watch(77, 200, 1'b0, -1, "rerun");
    chk("rerun_identical", bus.a_sbs, saved);

    // Reset mid-run at idx 100
    launch(200, 60, 1'b0);
    repeat (101) @(negedge clk);
    chk("abort_idx", SW'(bus.bit_idx), SW'(100));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", SW'(bus.busy), SW'(0));
    chk("abort_done", SW'(bus.done), SW'(0));
    chk("abort_valid", SW'(bus.bit_valid), SW'(0));
    chk("abort_sbs", bus.a_sbs, '0);
    chk("abort_bit_out", SW'(bus.bit_out), SW'(0));
    launch(200, 60, 1'b0);
    run_watch(200, 60, 1'b0, -1, "after_abort");

    // Randomized operands and modes against the model
    for (int r = 0; r < 6; r++) begin
      int ra0 = int'($urandom_range(0, 255));
      int ra1 = int'($urandom_range(0, 255));
      bit rc  = 1'($urandom_range(0, 1));
      launch(ra0, ra1, rc);
      run_watch(ra0, ra1, rc, -1, $sformatf("rnd%0d_a%0d_b%0d_c%0d", r, ra0, ra1, rc));
      chk($sformatf("rnd%0d_pop0", r), SW'($countones(bus.a_sbs[BSL-1:0])), SW'(ra0));
      chk($sformatf("rnd%0d_pop1", r), SW'($countones(bus.a_sbs[SW-1:BSL])), SW'(ra1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
